instr_fetch_unit: RTL and testbench

Fetch stage upstream of the multicycle control FSM for the 16-bit datapath. Holds the PC, runs a request/valid read handshake to instruction memory, and latches the returned word into the instruction register (IR). Decodes the IR into opCode1/opCode2/conditionCode/register/immediate fields consumed by the control FSM and datapath. Accepts jump/branch PC loads from the control FSM and times out stalled reads.

---
 rtl/instr_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a req/valid read to instruction
// memory, latches the returned word into IR and decodes its fields.
module instr_fetch_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic             pc_load,
  input  logic [WIDTH-1:0] pc_target,
  output logic             mem_rd,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_valid,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] link_pc,
  output logic             instr_valid,
  output logic [3:0]       opCode1,
  output logic [3:0]       rdest,
  output logic [3:0]       conditionCode,
  output logic [3:0]       opCode2,
  output logic [3:0]       rsrc,
  output logic [WIDTH-1:0] imm_zext,
  output logic [WIDTH-1:0] imm_sext,
  output logic             busy,
  output logic             fetch_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] link_pc_q, link_pc_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_q, pend_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             fetch_err_q, fetch_err_d;

  logic [WIDTH-1:0] next_seq;
  logic [WIDTH-1:0] redirect_tgt;
  logic             redirect;
  logic [7:0]       cnt_inc;

  // A load arriving in the same cycle as completion/abort overrides any
  // earlier pending target, so the newest redirect always wins.
  assign next_seq     = mem_addr_q + 1'b1;
  assign redirect     = pc_load | pend_q;
  assign redirect_tgt = pc_load ? pc_target : pend_tgt_q;
  assign cnt_inc      = cnt_q + 8'd1;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    link_pc_d   = link_pc_q;
    mem_addr_d  = mem_addr_q;
    pend_tgt_d  = pend_tgt_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    fetch_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          state_d    = READ;
          mem_addr_d = pc_load ? pc_target : pc_q;
          pc_d       = pc_load ? pc_target : pc_q;
          cnt_d      = 8'd0;
          pend_d     = 1'b0;
        end else if (pc_load) begin
          pc_d = pc_target;
        end
      end
      READ: begin
        if (mem_valid) begin
          ir_d      = mem_rdata;
          link_pc_d = next_seq;
          pc_d      = redirect ? redirect_tgt : next_seq;
          pend_d    = 1'b0;
          state_d   = VALID;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          cnt_d       = cnt_inc;
          state_d     = IDLE;
          fetch_err_d = 1'b1;
          pend_d      = 1'b0;
          if (redirect) pc_d = redirect_tgt;
        end else begin
          cnt_d = cnt_inc;
          if (pc_load) begin
            pend_d     = 1'b1;
            pend_tgt_d = pc_target;
          end
        end
      end
      VALID: begin
        state_d = IDLE;
        if (pc_load) pc_d = pc_target;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      link_pc_q   <= '0;
      mem_addr_q  <= '0;
      pend_tgt_q  <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      link_pc_q   <= link_pc_d;
      mem_addr_q  <= mem_addr_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_rd        = (state_q == READ);
  assign busy          = (state_q == READ);
  assign instr_valid   = (state_q == VALID);
  assign fetch_err     = fetch_err_q;
  assign mem_addr      = mem_addr_q;
  assign pc_out        = pc_q;
  assign link_pc       = link_pc_q;

  assign opCode1       = ir_q[15:12];
  assign rdest         = ir_q[11:8];
  assign conditionCode = ir_q[11:8];
  assign opCode2       = ir_q[7:4];
  assign rsrc          = ir_q[3:0];
  assign imm_zext      = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
  assign imm_sext      = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on instr_valid/fetch_err.
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, pc_load, mem_valid;
  logic [15:0] pc_target, mem_rdata;
  logic        mem_rd, instr_valid, busy, fetch_err;
  logic [15:0] mem_addr, pc_out, link_pc, imm_zext, imm_sext;
  logic [3:0]  opCode1, rdest, conditionCode, opCode2, rsrc;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        is_err;
    int          cyc;
    logic [15:0] pc, link, zext, sext;
    logic [3:0]  op1, rd, op2, rs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  instr_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_load(pc_load),
    .pc_target(pc_target), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .pc_out(pc_out),
    .link_pc(link_pc), .instr_valid(instr_valid), .opCode1(opCode1),
    .rdest(rdest), .conditionCode(conditionCode), .opCode2(opCode2),
    .rsrc(rsrc), .imm_zext(imm_zext), .imm_sext(imm_sext), .busy(busy),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output event must match the oldest expectation.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 || fetch_err === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_event", {30'd0, instr_valid, fetch_err}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("evt_fetch_err",   fetch_err, mon_e.is_err);
        check("evt_instr_valid", instr_valid, !mon_e.is_err);
        check("evt_cycle",       cyc, mon_e.cyc);
        check("evt_pc_out",      pc_out, mon_e.pc);
        check("evt_link_pc",     link_pc, mon_e.link);
        check("evt_opCode1",     opCode1, mon_e.op1);
        check("evt_rdest",       rdest, mon_e.rd);
        check("evt_condCode",    conditionCode, mon_e.rd);
        check("evt_opCode2",     opCode2, mon_e.op2);
        check("evt_rsrc",        rsrc, mon_e.rs);
        check("evt_imm_zext",    imm_zext, mon_e.zext);
        check("evt_imm_sext",    imm_sext, mon_e.sext);
        check("evt_busy",        busy, 1'b0);
      end
    end
  end

  function automatic exp_t mk(input logic is_err, input int c, input logic [15:0] pc,
                              input logic [15:0] link, input logic [3:0] op1,
                              input logic [3:0] rd, input logic [3:0] op2,
                              input logic [3:0] rs, input logic [15:0] zx,
                              input logic [15:0] sx);
    exp_t e;
    e.is_err = is_err; e.cyc = c; e.pc = pc; e.link = link;
    e.op1 = op1; e.rd = rd; e.op2 = op2; e.rs = rs; e.zext = zx; e.sext = sx;
    return e;
  endfunction

  // One fetch: request (optionally with a same-cycle load), `waits` stall
  // cycles (optional mid-READ load at wait index mid_at), then data.
  task automatic fetch(input logic [15:0] data, input int waits, input logic ld,
                       input logic [15:0] tgt, input int mid_at, input logic [15:0] mid_tgt,
                       input logic [15:0] e_addr, input logic [15:0] e_pc,
                       input logic [15:0] e_link, input logic [3:0] op1,
                       input logic [3:0] rd, input logic [3:0] op2, input logic [3:0] rs,
                       input logic [15:0] zx, input logic [15:0] sx);
    @(posedge clk); #1;
    fetch_req = 1'b1; pc_load = ld; pc_target = tgt;
    sb.push_back(mk(1'b0, cyc + waits + 2, e_pc, e_link, op1, rd, op2, rs, zx, sx));
    @(posedge clk); #1;
    fetch_req = 1'b0; pc_load = 1'b0;
    check("read_mem_rd", mem_rd, 1'b1);
    check("read_busy", busy, 1'b1);
    check("read_mem_addr", mem_addr, e_addr);
    for (int i = 0; i < waits; i++) begin
      if (i == mid_at) begin pc_load = 1'b1; pc_target = mid_tgt; end
      @(posedge clk); #1;
      pc_load = 1'b0;
      if (i + 1 < waits) check("wait_mem_addr_stable", mem_addr, e_addr);
    end
    mem_valid = 1'b1; mem_rdata = data;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_rdata = 16'h0000;
    @(posedge clk); #1;
  endtask

  task automatic idle_load(input logic [15:0] tgt);
    @(posedge clk); #1;
    pc_load = 1'b1; pc_target = tgt;
    @(posedge clk); #1;
    pc_load = 1'b0;
    check("idle_load_pc", pc_out, tgt);
    check("idle_load_busy", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; mem_valid = 1'b0;
    pc_target = 16'h0000; mem_rdata = 16'h0000;
    #3;
    check("rst_pc_out", pc_out, 16'h0000);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_fetch_err", fetch_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_imm_sext", imm_sext, 16'h0000);
    #19 reset = 1'b1;

    // Zero-wait fetch of 0531 at 0000.
    fetch(16'h0531, 0, 1'b0, 16'h0, -1, 16'h0, 16'h0000, 16'h0001, 16'h0001,
          4'h0, 4'h5, 4'h3, 4'h1, 16'h0031, 16'h0031);
    // Three wait cycles, negative immediate.
    fetch(16'hB3F6, 3, 1'b0, 16'h0, -1, 16'h0, 16'h0001, 16'h0002, 16'h0002,
          4'hB, 4'h3, 4'hF, 4'h6, 16'h00F6, 16'hFFF6);
    // Load in the same cycle as the request.
    fetch(16'h1234, 0, 1'b1, 16'h0040, -1, 16'h0, 16'h0040, 16'h0041, 16'h0041,
          4'h1, 4'h2, 4'h3, 4'h4, 16'h0034, 16'h0034);
    // Mid-READ redirect to 0100 while fetching 0007.
    idle_load(16'h0007);
    fetch(16'h4C85, 2, 1'b0, 16'h0, 0, 16'h0100, 16'h0007, 16'h0100, 16'h0008,
          4'h4, 4'hC, 4'h8, 4'h5, 16'h0085, 16'hFF85);
    // PC wrap at FFFF.
    idle_load(16'hFFFF);
    fetch(16'h7F80, 1, 1'b0, 16'h0, -1, 16'h0, 16'hFFFF, 16'h0000, 16'h0000,
          4'h7, 4'hF, 4'h8, 4'h0, 16'h0080, 16'hFF80);

    // Timeout: memory never answers.
    @(posedge clk); #1;
    fetch_req = 1'b1;
    sb.push_back(mk(1'b1, cyc + TIMEOUT + 1, 16'h0000, 16'h0000,
                    4'h7, 4'hF, 4'h8, 4'h0, 16'h0080, 16'hFF80));
    @(posedge clk); #1;
    fetch_req = 1'b0;
    check("to_busy", busy, 1'b1);
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("to_bounded", n < 40, 1'b1);
    // mem_valid while IDLE must be ignored (monitor flags any instr_valid).
    mem_valid = 1'b1; mem_rdata = 16'hFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    check("to_ir_kept", opCode1, 4'h7);
    check("to_pc_out", pc_out, 16'h0000);

    // Reset in the middle of a read.
    idle_load(16'h0020);
    @(posedge clk); #1;
    fetch_req = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0;
    check("mid_busy", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mrst_busy", busy, 1'b0);
    check("mrst_mem_rd", mem_rd, 1'b0);
    check("mrst_mem_addr", mem_addr, 16'h0000);
    check("mrst_pc_out", pc_out, 16'h0000);
    check("mrst_link_pc", link_pc, 16'h0000);
    check("mrst_opCode1", opCode1, 4'h0);
    check("mrst_imm_zext", imm_zext, 16'h0000);
    mem_valid = 1'b1; mem_rdata = 16'h5555;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    check("post_rst_pc_out", pc_out, 16'h0000);
    check("post_rst_rdest", rdest, 4'h0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
